greenman_matrix: RTL and testbench

- Drives an 8x8 LED dot-matrix with a four-frame "walking green man" pedestrian animation.
- Sits beside the traffic-light sequencer, which asserts greenmanon while the pedestrian phase is active.
- Performs row-multiplexed scanning and frame sequencing from a single system clock.
- Outputs are blank whenever greenmanon is low.

---
 rtl/greenman_matrix.sv | 149 ++++++++++++++
 tb/tb_greenman_matrix.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/greenman_matrix.sv
// Walking green man 8x8 LED matrix driver: row-multiplexed scan plus a
// four-frame animation that runs only while greenmanon is high.
module greenman_matrix #(
  parameter int unsigned SCAN_DIV  = 4096,
  parameter int unsigned FRAME_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       greenmanon,
  output logic [7:0] vert,
  output logic [7:0] hori
);

  localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FrameW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [ScanW-1:0]  ScanMax  = ScanW'(SCAN_DIV - 1);
  localparam logic [FrameW-1:0] FrameMax = FrameW'(FRAME_DIV - 1);

  logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [2:0]        row_q, row_d;
  logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]        frame_q, frame_d;
  logic [7:0]        vert_q, vert_d;
  logic [7:0]        hori_q, hori_d;
  logic [7:0]        rom_data;

  // Bitmap rows, bit 7 is the leftmost column.
  function automatic logic [7:0] rom_lookup(input logic [1:0] f, input logic [2:0] r);
    logic [7:0] data;
    data = 8'h00;
    unique case (f)
      2'd0: begin
        unique case (r)
          3'd0: data = 8'h18;
          3'd1: data = 8'h18;
          3'd2: data = 8'h3C;
          3'd3: data = 8'h5A;
          3'd4: data = 8'h18;
          3'd5: data = 8'h24;
          3'd6: data = 8'h24;
          3'd7: data = 8'h66;
          default: data = 8'h00;
        endcase
      end
      2'd1: begin
        unique case (r)
          3'd0: data = 8'h18;
          3'd1: data = 8'h18;
          3'd2: data = 8'h3C;
          3'd3: data = 8'h5A;
          3'd4: data = 8'h18;
          3'd5: data = 8'h24;
          3'd6: data = 8'h42;
          3'd7: data = 8'hC3;
          default: data = 8'h00;
        endcase
      end
      2'd2: begin
        unique case (r)
          3'd0: data = 8'h18;
          3'd1: data = 8'h18;
          3'd2: data = 8'h7C;
          3'd3: data = 8'h9A;
          3'd4: data = 8'h18;
          3'd5: data = 8'h28;
          3'd6: data = 8'h48;
          3'd7: data = 8'h8C;
          default: data = 8'h00;
        endcase
      end
      2'd3: begin
        unique case (r)
          3'd0: data = 8'h18;
          3'd1: data = 8'h18;
          3'd2: data = 8'h3E;
          3'd3: data = 8'h59;
          3'd4: data = 8'h18;
          3'd5: data = 8'h14;
          3'd6: data = 8'h12;
          3'd7: data = 8'h31;
          default: data = 8'h00;
        endcase
      end
      default: data = 8'h00;
    endcase
    return data;
  endfunction

  // Row scan free-runs so the display phase is independent of the enable.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    row_d      = row_q;
    if (scan_cnt_q == ScanMax) begin
      scan_cnt_d = '0;
      row_d      = row_q + 3'd1;
    end
  end

  // Holding the frame state at zero while disabled makes every enable start
  // on frame 0 with a full frame period.
  always_comb begin
    frame_cnt_d = '0;
    frame_d     = 2'd0;
    if (greenmanon) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
      frame_d     = frame_q;
      if (frame_cnt_q == FrameMax) begin
        frame_cnt_d = '0;
        frame_d     = frame_q + 2'd1;
      end
    end
  end

  assign rom_data = rom_lookup(frame_q, row_q);

  always_comb begin
    vert_d = 8'h00;
    hori_d = 8'h00;
    if (greenmanon) begin
      vert_d = 8'h01 << row_q;
      hori_d = rom_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q  <= '0;
      row_q       <= 3'd0;
      frame_cnt_q <= '0;
      frame_q     <= 2'd0;
      vert_q      <= 8'h00;
      hori_q      <= 8'h00;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      row_q       <= row_d;
      frame_cnt_q <= frame_cnt_d;
      frame_q     <= frame_d;
      vert_q      <= vert_d;
      hori_q      <= hori_d;
    end
  end

  assign vert = vert_q;
  assign hori = hori_q;

  vert_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(vert_q));

endmodule

// File: tb/tb_greenman_matrix.sv
// Randomized bench for greenman_matrix against a cycle-count reference model.
module tb_greenman_matrix;

  localparam int unsigned ScanDiv  = 4;
  localparam int unsigned FrameDiv = 64;

  localparam logic [7:0] ROM [4][8] = '{
    '{8'h18, 8'h18, 8'h3C, 8'h5A, 8'h18, 8'h24, 8'h24, 8'h66},
    '{8'h18, 8'h18, 8'h3C, 8'h5A, 8'h18, 8'h24, 8'h42, 8'hC3},
    '{8'h18, 8'h18, 8'h7C, 8'h9A, 8'h18, 8'h28, 8'h48, 8'h8C},
    '{8'h18, 8'h18, 8'h3E, 8'h59, 8'h18, 8'h14, 8'h12, 8'h31}
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       greenmanon = 1'b0;
  logic [7:0] vert;
  logic [7:0] hori;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  // Model state: edges since reset release, and consecutive enabled edges.
  int unsigned t_model = 0;
  int unsigned e_model = 0;

  greenman_matrix #(
    .SCAN_DIV (ScanDiv),
    .FRAME_DIV(FrameDiv)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .greenmanon(greenmanon),
    .vert      (vert),
    .hori      (hori)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock with the given enable; checks outputs 1ns after the edge.
  task automatic step(input logic en);
    logic [7:0] ev;
    logic [7:0] eh;
    int unsigned r;
    int unsigned f;
    greenmanon = en;
    @(posedge clk);
    r  = (t_model / ScanDiv) % 8;
    f  = (e_model / FrameDiv) % 4;
    ev = en ? (8'h01 << r) : 8'h00;
    eh = en ? ROM[f][r] : 8'h00;
    t_model++;
    e_model = en ? e_model + 1 : 0;
    #1;
    check_eq("vert", vert, ev);
    check_eq("hori", hori, eh);
    check_eq("onehot0", {7'd0, $onehot0(vert)}, 8'd1);
    if (vert == 8'h00) check_eq("blank_hori", hori, 8'h00);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_vert", vert, 8'h00);
    check_eq("rst_hori", hori, 8'h00);
    #2;
    rst_n   = 1'b1;
    t_model = 0;
    e_model = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("por_vert", vert, 8'h00);
    check_eq("por_hori", hori, 8'h00);
    #2;
    rst_n = 1'b1;

    // First output after release.
    step(1'b1);
    check_eq("first_vert", vert, 8'h01);
    check_eq("first_hori", hori, 8'h18);

    // Row scan and frame advance/wrap, fresh from reset mid-run.
    for (int i = 0; i < 20; i++) step(1'b1);
    pulse_reset();
    for (int k = 0; k < 300; k++) begin
      step(1'b1);
      if (k == 4)   check_eq("f0_row1", vert, 8'h02);
      if (k == 88)  check_eq("f1_row6", hori, 8'h42);
      if (k == 92)  check_eq("f1_row7", hori, 8'hC3);
      if (k == 284) check_eq("f0_wrap_row7", hori, 8'h66);
    end

    // Disable while in frame 2, then re-enable.
    for (int i = 0; i < 400 && ((e_model / FrameDiv) % 4) != 2; i++) step(1'b1);
    for (int i = 0; i < 10; i++) step(1'b1);
    step(1'b0);
    check_eq("dis_vert", vert, 8'h00);
    check_eq("dis_hori", hori, 8'h00);
    step(1'b1);
    check_eq("reen_f0", hori, ROM[0][((t_model - 1) / ScanDiv) % 8]);

    // Blank for 100 clocks starting on a full scan cycle boundary.
    for (int i = 0; i < 64 && (t_model % (8 * ScanDiv)) != 0; i++) step(1'b1);
    for (int i = 0; i < 100; i++) step(1'b0);
    step(1'b1);
    check_eq("reen_row", vert, 8'h02);

    // Random enable runs with occasional mid-run resets.
    for (int n = 0; n < 10000; ) begin
      logic en;
      int unsigned len;
      en  = 1'($urandom_range(1, 0));
      len = $urandom_range(150, 1);
      for (int i = 0; i < len; i++) step(en);
      n += len;
      if ($urandom_range(19, 0) == 0) pulse_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
